// File: rtl/team_06_env_pkg.sv
// Shared FSM state encoding and default tuning constants for the envelope follower.
package team_06_env_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } env_state_t;

    localparam int ATTACK_SHIFT_DEF = 2;
    localparam int HOLD_SAMPLES_DEF = 8;
    localparam int RELEASE_DIV_DEF  = 16;

endpackage

// File: rtl/team_06_env_counter.sv
// Modulo-MOD sample counter with synchronous clear; tc flags that the next increment wraps to 0.
module team_06_env_counter #(
    parameter int MOD = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);
    localparam int CW = (MOD > 1) ? $clog2(MOD) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= tc ? '0 : count + CW'(1);
        end
    end

    assign tc = (count == CW'(MOD - 1));

endmodule

// File: rtl/team_06_envelope_follower.sv
// Attack/hold/release envelope follower for an 8-bit magnitude stream, 1-cycle latency.
// Define TEAM06_ENV_DIR_EN to register env_dir; otherwise env_dir is tied high.
module team_06_envelope_follower
    import team_06_env_pkg::*;
#(
    parameter int ATTACK_SHIFT = ATTACK_SHIFT_DEF,
    parameter int HOLD_SAMPLES = HOLD_SAMPLES_DEF,
    parameter int RELEASE_DIV  = RELEASE_DIV_DEF
) (
    input  logic       clkdiv,
    input  logic       rst,
    input  logic       en,
    input  logic       sample_valid,
    input  logic [7:0] audio_in,
    output logic [7:0] envelope,
    output logic       env_valid,
    output logic       env_dir
);
    env_state_t state;
    logic       accepted, rising;
    logic       hold_inc, hold_clr, hold_tc;
    logic       rel_inc, rel_clr, rel_tc;
    logic [8:0] diff, step, sum;
    logic [7:0] env_up;

    assign accepted = en && sample_valid;
    assign rising   = audio_in > envelope;

    always_comb begin
        diff = {1'b0, audio_in} - {1'b0, envelope};
        step = diff >> ATTACK_SHIFT;
        if (step == 9'd0) begin
            step = 9'd1;
        end
        sum    = {1'b0, envelope} + step;
        env_up = (sum > 9'd255) ? 8'd255 : sum[7:0];
    end

    // IDLE counts its first non-rising sample like HOLD does.
    assign hold_inc = accepted && !rising && (state != RELEASE);
    assign hold_clr = !en || (accepted && rising);
    assign rel_inc  = accepted && !rising && (state == RELEASE);
    assign rel_clr  = !en || (accepted && rising) || (hold_inc && hold_tc);

    team_06_env_counter #(.MOD(HOLD_SAMPLES)) u_hold_cnt (
        .clk (clkdiv),
        .rst (rst),
        .clr (hold_clr),
        .inc (hold_inc),
        .tc  (hold_tc)
    );

    team_06_env_counter #(.MOD(RELEASE_DIV)) u_rel_cnt (
        .clk (clkdiv),
        .rst (rst),
        .clr (rel_clr),
        .inc (rel_inc),
        .tc  (rel_tc)
    );

`ifndef TEAM06_ENV_DIR_EN
    assign env_dir = 1'b1;
`endif

    always_ff @(posedge clkdiv or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            envelope  <= 8'd0;
            env_valid <= 1'b0;
`ifdef TEAM06_ENV_DIR_EN
            env_dir   <= 1'b1;
`endif
        end else if (!en) begin
            state     <= IDLE;
            envelope  <= 8'd0;
            env_valid <= 1'b0;
        end else begin
            env_valid <= sample_valid;
            if (sample_valid) begin
                if (rising) begin
                    state    <= ATTACK;
                    envelope <= env_up;
`ifdef TEAM06_ENV_DIR_EN
                    env_dir  <= 1'b1;
`endif
                end else if (state != RELEASE) begin
                    state <= hold_tc ? RELEASE : HOLD;
                end else if (rel_tc && (envelope > audio_in)) begin
                    envelope <= envelope - 8'd1;
`ifdef TEAM06_ENV_DIR_EN
                    env_dir  <= 1'b0;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_team_06_envelope_follower.sv
// Randomized and directed bench for team_06_envelope_follower against a rule-level reference model.
module tb_team_06_envelope_follower;
    localparam int ATT_SH  = 2;
    localparam int HOLD_N  = 8;
    localparam int REL_DIV = 16;

    logic       clkdiv = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       sample_valid = 1'b0;
    logic [7:0] audio_in = 8'd0;
    logic [7:0] envelope;
    logic       env_valid;
    logic       env_dir;

    int total = 0;
    int bad   = 0;

    // Reference model: phase 0=idle 1=attack 2=hold 3=release
    int m_env, m_phase, m_held, m_since;
    bit m_vld, m_dir;

    team_06_envelope_follower #(
        .ATTACK_SHIFT(ATT_SH),
        .HOLD_SAMPLES(HOLD_N),
        .RELEASE_DIV (REL_DIV)
    ) dut (
        .clkdiv      (clkdiv),
        .rst         (rst),
        .en          (en),
        .sample_valid(sample_valid),
        .audio_in    (audio_in),
        .envelope    (envelope),
        .env_valid   (env_valid),
        .env_dir     (env_dir)
    );

    always #5 clkdiv = ~clkdiv;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_dir();
`ifdef TEAM06_ENV_DIR_EN
        return m_dir;
`else
        return 1'b1;
`endif
    endfunction

    function automatic void model_reset();
        m_env = 0; m_phase = 0; m_held = 0; m_since = 0; m_vld = 0; m_dir = 1;
    endfunction

    function automatic void model_step(bit e, bit v, int a);
        int s;
        if (!e) begin
            m_env = 0; m_phase = 0; m_held = 0; m_since = 0; m_vld = 0;
            return;
        end
        m_vld = v;
        if (!v) return;
        if (a > m_env) begin
            s = (a - m_env) / (1 << ATT_SH);
            if (s < 1) s = 1;
            m_env = (m_env + s > 255) ? 255 : m_env + s;
            m_phase = 1; m_held = 0; m_since = 0; m_dir = 1;
        end else if (m_phase != 3) begin
            m_held++;
            m_phase = 2;
            if (m_held == HOLD_N) begin
                m_phase = 3; m_held = 0; m_since = 0;
            end
        end else begin
            m_since++;
            if (m_since == REL_DIV) begin
                m_since = 0;
                if (m_env > a) begin
                    m_env--;
                    m_dir = 0;
                end
            end
        end
    endfunction

    // Called at a negedge; applies one edge of stimulus and checks the result at the next negedge.
    task automatic cyc(input bit e, input bit v, input int a);
        en = e; sample_valid = v; audio_in = 8'(a);
        @(posedge clkdiv);
        model_step(e, v, a);
        @(negedge clkdiv);
        chk("envelope", envelope, m_env);
        chk("env_valid", env_valid, m_vld);
        chk("env_dir", env_dir, exp_dir());
    endtask

    task automatic reset_pulse();
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_envelope", envelope, 0);
        chk("rst_env_valid", env_valid, 0);
        chk("rst_env_dir", env_dir, 1);
        @(negedge clkdiv);
        rst = 1'b0;
    endtask

    initial begin
        int guard;
        model_reset();
        @(negedge clkdiv);
        chk("por_envelope", envelope, 0);
        chk("por_env_valid", env_valid, 0);
        chk("por_env_dir", env_dir, 1);
        rst = 1'b0;

        // Attack from silence: 0 -> 50 -> 87
        cyc(1, 1, 200);
        chk("atk1", envelope, 50);
        cyc(1, 1, 200);
        chk("atk2", envelope, 87);
        cyc(1, 0, 0);
        chk("vld_gap", env_valid, 0);

        // Hold for 8 quiet samples, then one LSB of release per 16
        for (int i = 0; i < HOLD_N; i++) cyc(1, 1, 0);
        chk("hold_env", envelope, 87);
        for (int i = 0; i < REL_DIV - 1; i++) cyc(1, 1, 0);
        chk("rel_early", envelope, 87);
        cyc(1, 1, 0);
        chk("rel_step", envelope, 86);
`ifdef TEAM06_ENV_DIR_EN
        chk("rel_dir", env_dir, 0);
`else
        chk("rel_dir", env_dir, 1);
`endif

        // Async reset mid-release, between edges
        for (int i = 0; i < 5; i++) cyc(1, 1, 0);
        reset_pulse();

        // Release floor at the input level
        cyc(1, 1, 160);
        chk("floor_atk", envelope, 40);
        for (int i = 0; i < HOLD_N + 2 * REL_DIV; i++) cyc(1, 1, 40);
        chk("floor_hold", envelope, 40);

        // en low for one edge clears and suppresses env_valid
        cyc(0, 1, 100);
        chk("en0_env", envelope, 0);
        chk("en0_vld", env_valid, 0);

        // Saturation near full scale
        guard = 0;
        while (m_env != 254 && guard < 64) begin
            cyc(1, 1, 254);
            guard++;
        end
        chk("reach254", envelope, 254);
        cyc(1, 1, 255);
        chk("sat_step", envelope, 255);
        for (int i = 0; i < 4; i++) cyc(1, 1, 255);
        chk("sat_hold", envelope, 255);

        // Randomized: tremolo-like bursts mixed with noise, gaps, en drops and resets
        for (int i = 0; i < 1500; i++) begin
            int a;
            if ($urandom_range(0, 199) == 0) begin
                reset_pulse();
            end else begin
                if ((i / 60) % 2 == 0) a = int'($urandom_range(120, 255));
                else                   a = int'($urandom_range(0, 60));
                if ($urandom_range(0, 9) == 0) a = int'($urandom_range(0, 255));
                cyc($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, a);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/team_06_envelope_follower.md
TEAM_06_ENVELOPE_FOLLOWER -- requirements
Module: team_06_envelope_follower

Interface
REQ-001 SHALL have parameter ATTACK_SHIFT, default 2, attack step = (audio_in - envelope) >> ATTACK_SHIFT.
REQ-002 SHALL have parameter HOLD_SAMPLES, default 8, number of non-rising samples held before release.
REQ-003 SHALL have parameter RELEASE_DIV, default 16, number of samples per 1-LSB release decrement.
REQ-004 SHALL have port clkdiv, input, 1, sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port en, input, 1, block enable.
REQ-007 SHALL have port sample_valid, input, 1, audio_in qualifier, one sample per high cycle.
REQ-008 SHALL have port audio_in, input, 8, unsigned magnitude sample, 0 = silence; a tremolo-modulated stream is the intended input.
REQ-009 SHALL have port envelope, output, 8, registered recovered amplitude envelope.
REQ-010 SHALL have port env_valid, output, 1, one-cycle pulse when envelope reflects a newly accepted sample.
REQ-011 SHALL have port env_dir, output, 1, recovered modulation direction: 1 = rising, 0 = falling.

Function
REQ-012 SHALL accept a sample only on a clkdiv edge with en=1 and sample_valid=1; all other cycles leave envelope and counters unchanged.
REQ-013 SHALL implement FSM states IDLE, ATTACK, HOLD, RELEASE, encoded in the shared enum.
REQ-014 IDLE: on an accepted sample SHALL go to ATTACK if audio_in > envelope, else to HOLD.
REQ-015 Any state, accepted sample with audio_in > envelope: envelope += max(1, (audio_in - envelope) >> ATTACK_SHIFT); state ATTACK; hold count cleared.
REQ-016 ATTACK or HOLD, accepted sample with audio_in <= envelope: state HOLD; hold count increments; at HOLD_SAMPLES accepted samples SHALL go to RELEASE with release count cleared.
REQ-017 RELEASE, accepted sample with audio_in <= envelope: release count increments; on reaching RELEASE_DIV it wraps to 0, and envelope decrements by 1 only if envelope > audio_in.
REQ-018 Envelope SHALL never exceed 255, never underflow below 0, and never release below the current audio_in.
REQ-019 env_valid SHALL assert exactly one cycle after each accepted sample (latency 1) and stay 0 otherwise.
REQ-020 en=0 SHALL force IDLE, clear envelope and both counters on the next edge, and hold env_valid at 0.
REQ-021 Arithmetic SHALL use 9-bit intermediates for differences and sums; truncation to 8 bits only after saturation.

Reset
REQ-022 rst=1 SHALL immediately force envelope=0, env_valid=0, env_dir=1, state IDLE, hold and release counts 0, regardless of clkdiv.
REQ-023 Reset asserted mid-attack or mid-release SHALL discard the in-progress count; the first accepted sample after release of rst is handled from IDLE.

Configuration
REQ-024 Macro TEAM06_ENV_DIR_EN defined: env_dir updates on each accepted sample to 1 if envelope increased, 0 if it decreased, unchanged if equal.
REQ-025 Macro TEAM06_ENV_DIR_EN undefined: env_dir SHALL be tied to constant 1 and no direction register is synthesized.

Structure
REQ-026 Package team_06_env_pkg SHALL hold the FSM state enum and the default constants for ATTACK_SHIFT, HOLD_SAMPLES and RELEASE_DIV.
REQ-027 One sub-module team_06_env_counter (parameterized modulo sample counter with clear, increment and terminal-count output) SHALL be instantiated twice, for hold and for release.

Verification
REQ-028 Reset, en=1, samples 200,200 -> envelope 50 then 87, env_valid one cycle after each sample, env_dir=1.
REQ-029 Envelope 87, then 8 samples of 0 -> envelope stays 87 in HOLD, RELEASE entered after 8th; next 16 samples of 0 -> envelope 86, env_dir=0.
REQ-030 In RELEASE with envelope 40, 32 samples of 40 -> envelope stays 40, no release below input.
REQ-031 Envelope 254, sample 255 -> step computes 0, forced to 1, envelope 255; further 255 samples -> stays 255.
REQ-032 rst pulsed between clkdiv edges mid-release -> envelope 0, env_valid 0, env_dir 1 immediately; en=0 for one edge with valid samples -> envelope 0, no env_valid.
REQ-033 Build without TEAM06_ENV_DIR_EN, rerun REQ-029 -> env_dir constant 1, envelope values identical.
